uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler and baud-tick generator that shares a single 8N1 UART transmitter between up to NREQ byte producers. It accepts bytes over per-requester valid/ready handshakes, drives the transmitter's `tx_start`/`tx_data`/`tx_enb` inputs and tracks its `tx_busy` output. It enforces a full stop-bit guard period between frames. It sits between the on-chip byte sources and the transmitter instance.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DIV_W`, default 16: width of the baud divisor.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `baud_div`  in  DIV_W  baud tick period minus one, in clk cycles; quasi-static.
- `req_valid`  in  NREQ  requester i has a byte pending.
- `req_data`  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_enb`  out  1  baud tick to the transmitter, one cycle wide.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  8  byte presented to the transmitter, held until the next launch.
- `tx_busy`  in  1  busy flag from the transmitter.
- `grant_id`  out  $clog2(NREQ)  index of the requester owning the current or last frame.
- `active`  out  1  high from acceptance until the guard period completes.
- `err`  out  1  one-cycle pulse on launch timeout; see Configuration.

## Operation
- Baud generator: a free-running counter `cnt` counts up. When `cnt >= baud_div`, `tx_enb` is high for that cycle and `cnt` is set to 0. With `baud_div = 0`, `tx_enb` is high every cycle. Shrinking `baud_div` below `cnt` produces a tick on the next cycle.
- Arbiter: round-robin with a last-grant pointer `ptr`. The search starts at `ptr+1` mod NREQ, and the first requester with `req_valid` set wins. `ptr` updates to the winner only on acceptance. Non-winners are never starved: each requester waits at most NREQ-1 frames.
- FSM states:
  - S_IDLE: `req_ready` equals the one-hot winner, combinational. On acceptance, `tx_data <= req_data[winner]`, `grant_id <= winner`, `tx_start <= 1`, go to S_LAUNCH. With no valid request, stay.
  - S_LAUNCH: `tx_start` high for exactly this cycle, then go to S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for `tx_busy = 1`, then go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for `tx_busy = 0`, then go to S_GUARD.
  - S_GUARD: wait for the next `tx_enb` pulse, then go to S_IDLE. This pads the stop bit to at least one full baud period.
- `req_ready` is all-zero in every state except S_IDLE and while `rst_n` is low.
- `active` is high in S_LAUNCH through S_GUARD.
- A requester must hold `req_valid` and its data stable until accepted. The block never drops a valid request and never transfers two bytes per frame.
- Reset mid-frame: the FSM returns to S_IDLE and `cnt` clears. No byte is re-sent. The transmitter has its own reset, and this block does not wait for it.

## Timing
- Reset values: `tx_enb` 0, `tx_start` 0, `tx_data` 8'h00, `req_ready` all 0, `grant_id` 0, `active` 0, `err` 0, `cnt` 0.
- Reset value of `ptr` is NREQ-1, so requester 0 has first priority.
- Acceptance in cycle N leads to `tx_start` high in cycle N+1 and `tx_busy` high from cycle N+2.
- Next acceptance: no earlier than the cycle after the first `tx_enb` that follows `tx_busy` falling.
- `tx_enb` keeps running in all states; it is never gated by the FSM.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined: S_WAIT_BUSY has a 4-bit cycle counter. If `tx_busy` has not risen after 15 cycles in S_WAIT_BUSY, the block pulses `err` for one cycle and returns to S_IDLE. The byte is dropped and `ptr` keeps the winner.
- `UART_TX_SCHED_TIMEOUT_EN` undefined: S_WAIT_BUSY waits indefinitely and `err` is tied to 0.

## Test plan
- Single byte: `baud_div = 3`, requester 0 sends 8'hA5. `req_ready[0]` pulses once, `tx_start` pulses one cycle later with `tx_data = 8'hA5`, and the line carries the frame 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles.
- Fairness: `req_valid = 4'b1111` held, each requester refilled after acceptance. Grant order is 0,1,2,3,0,1.
- Late arrival: requester 2 waits while 0 and 3 alternate. Requester 2 is granted within 3 frames.
- Spacing: `baud_div = 0`, back-to-back requests. There is at least one `tx_enb` between `tx_busy` falling and the next `tx_start`, and `active` deasserts for exactly one cycle between frames.
- Reset mid-frame: `rst_n` is pulled low during the DATA phase. All outputs reach reset values the cycle after, and after release the pending request is accepted first by requester 0.
- Timeout (macro defined): `tx_busy` tied to 0 and one request made. `err` pulses 16 cycles after `tx_start`, and the FSM then returns to S_IDLE.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler and free-running baud-tick generator sharing one 8N1 transmitter.
// Optional launch timeout in S_WAIT_BUSY is compiled in when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIV_W-1:0]        baud_div,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_enb,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    err
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GUARD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [PW-1:0]    winner, idx;
  logic             found, wrap;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [3:0]       to_q, to_d;
`endif

  // The tick is masked while reset is held so tx_enb reads 0 even with baud_div = 0.
  assign wrap   = (cnt_q >= baud_div);
  assign cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
  assign tx_enb = rst_n & wrap;

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    req_ready = '0;
    err       = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found && rst_n) begin
          req_ready = NREQ'(1) << winner;
          data_d    = req_data[{winner, 3'b000} +: 8];
          grant_d   = winner;
          ptr_d     = winner;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == 4'hF) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 4'd1;
        end
`else
        if (tx_busy) state_d = S_WAIT_DONE;
`endif
      end
      S_WAIT_DONE: if (!tx_busy) state_d = S_GUARD;
      // Hold off the next launch for one full baud period after the stop bit.
      S_GUARD: if (wrap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  assign tx_start = (state_q == S_LAUNCH);
  assign active   = (state_q != S_IDLE);
  assign tx_data  = data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural 8N1 transmitter stub plus a timeline/round-robin reference model.
module tb_uart_tx_sched;
  localparam int NREQ  = 4;
  localparam int DIV_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIV_W-1:0]  baud_div;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_enb, tx_start, tx_busy, active, err;
  logic [7:0]        tx_data;
  logic [1:0]        grant_id;

  uart_tx_sched #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_enb(tx_enb), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  // Transmitter stub: busy from the edge after tx_start, one bit per tick, busy drops after the stop bit.
  logic       busy_m, line_m, tx_dead;
  logic [9:0] sh_m;
  int         pos_m;
  logic       frame_bits[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      line_m <= 1'b1;
      pos_m  <= 0;
    end else if (tx_start && !tx_dead) begin
      busy_m <= 1'b1;
      sh_m   <= {1'b1, tx_data, 1'b0};
      pos_m  <= 0;
    end else if (busy_m && tx_enb) begin
      if (pos_m > 0) frame_bits.push_back(line_m);
      if (pos_m == 10) busy_m <= 1'b0;
      else begin
        line_m <= sh_m[pos_m];
        pos_m  <= pos_m + 1;
      end
    end
  end
  assign tx_busy = busy_m;

  int errors = 0;
  int checks = 0;
  int ncyc = 0, since = 0, mptr = NREQ - 1, t_start = -100, exp_gid = 0, nacc = 0;
  int t_start_obs = -1, t_err_obs = -1, lowrun = 0;
  logic open = 1'b0, busy_wait = 1'b0, busy_run = 1'b0, fell_wait = 1'b0, start_due = 1'b0;
  logic armed = 1'b0, gap_track = 1'b0, seen_act = 1'b0;
  logic [7:0] exp_byte = 8'h00;
  logic [NREQ-1:0] acc_mask = '0;
  int left[NREQ];
  int grants[$];
  int gaps[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then let producers refill.
  task automatic cyc();
    logic [NREQ-1:0] exp_ready;
    logic exp_tick, exp_err;
    int w, a;
    @(negedge clk);
    ncyc++;
    exp_tick = rst_n && (since >= int'(baud_div));
    exp_err  = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    if (rst_n && busy_wait && !tx_busy && ncyc == t_start + 16) exp_err = 1'b1;
`endif
    w = rr_pick(mptr, req_valid);
    exp_ready = (rst_n && !open && w >= 0) ? NREQ'(1) << w : '0;
    if (armed) begin
      check("tx_enb", tx_enb, exp_tick);
      check("req_ready", req_ready, exp_ready);
      check("active", active, open);
      check("tx_start", tx_start, start_due);
      check("err", err, exp_err);
      if (start_due) begin
        check("tx_data", tx_data, exp_byte);
        check("grant_id", grant_id, exp_gid);
      end
      if (gap_track) begin
        if (active) begin
          if (seen_act && lowrun > 0) gaps.push_back(lowrun);
          seen_act = 1'b1;
          lowrun = 0;
        end else if (seen_act) lowrun++;
      end
    end
    if (tx_start) t_start_obs = ncyc;
    if (err) t_err_obs = ncyc;
    if (!rst_n) begin
      open = 1'b0; busy_wait = 1'b0; busy_run = 1'b0; fell_wait = 1'b0; start_due = 1'b0;
      mptr = NREQ - 1; since = 0; acc_mask = '0;
    end else begin
      since = exp_tick ? 0 : since + 1;
      if (start_due) t_start = ncyc;
      start_due = 1'b0;
      if (exp_err) begin open = 1'b0; busy_wait = 1'b0; end
      else if (fell_wait && exp_tick) begin open = 1'b0; fell_wait = 1'b0; end
      else if (busy_run && !tx_busy) begin busy_run = 1'b0; fell_wait = 1'b1; end
      else if (busy_wait && tx_busy) begin busy_wait = 1'b0; busy_run = 1'b1; end
      acc_mask = req_valid & req_ready;
      if (acc_mask != '0) begin
        a = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (acc_mask[i]) a = i;
        open = 1'b1; busy_wait = 1'b1; start_due = 1'b1;
        mptr = a; exp_gid = a; exp_byte = req_data[a*8 +: 8];
        grants.push_back(a);
        nacc++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) begin
        if (left[i] > 0) begin
          left[i]--;
          req_data[i*8 +: 8] = 8'($urandom);
        end else req_valid[i] = 1'b0;
      end
    end
    acc_mask = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    armed = 1'b1;
    cyc();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_err", err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_enb", tx_enb, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((open || req_valid != '0 || tx_busy) && n < budget) begin
      cyc();
      n++;
    end
    check(tag, (!open && req_valid == '0 && !tx_busy), 1);
  endtask

  initial begin
    int n, n0, base, pos;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [9:0] got;
    rst_n = 1'b0; baud_div = 16'd3; req_valid = '0; req_data = '0; tx_dead = 1'b0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;

    // Single byte A5 at baud_div 3
    do_reset();
    frame_bits.delete();
    n0 = nacc;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_idle("single_done", 400);
    check("single_accepts", nacc - n0, 1);
    check("frame_len", frame_bits.size(), 10);
    got = '0;
    foreach (frame_bits[i]) got = {got[8:0], frame_bits[i]};
    check("frame_bits", got, 10'b0101001011);

    // Fairness with all four requesters busy
    baud_div = 16'($urandom_range(0, 3));
    do_reset();
    grants.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*8 +: 8] = 8'($urandom);
      left[i] = 1;
    end
    req_valid = '1;
    wait_idle("fair_done", 4000);
    check("fair_count", grants.size(), 8);
    for (int i = 0; i < 6; i++)
      check("fair_order", (i < grants.size()) ? grants[i] : -1, exp_order[i]);

    // Late arrival of requester 2 while 0 and 3 alternate
    baud_div = 16'd1;
    do_reset();
    grants.delete();
    req_data[7:0] = 8'($urandom);
    req_data[31:24] = 8'($urandom);
    left[0] = 4; left[3] = 4;
    req_valid = 4'b1001;
    n = 0;
    while (grants.size() < 2 && n < 2000) begin cyc(); n++; end
    check("late_pre", grants.size() >= 2, 1);
    base = grants.size();
    req_data[23:16] = 8'($urandom);
    left[2] = 0;
    req_valid[2] = 1'b1;
    wait_idle("late_done", 6000);
    pos = -1;
    for (int j = base; j < grants.size(); j++)
      if (grants[j] == 2 && pos < 0) pos = j - base + 1;
    check("late_frames", (pos >= 1 && pos <= 3), 1);

    // Back-to-back frames at baud_div 0
    baud_div = 16'd0;
    do_reset();
    grants.delete(); gaps.delete();
    gap_track = 1'b1; seen_act = 1'b0; lowrun = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*8 +: 8] = 8'($urandom);
      left[i] = 2;
    end
    req_valid = '1;
    wait_idle("space_done", 4000);
    gap_track = 1'b0;
    check("space_gaps", gaps.size(), 11);
    foreach (gaps[i]) check("space_gap", gaps[i], 1);

    // Reset during the data bits of a frame
    baud_div = 16'd3;
    do_reset();
    grants.delete();
    req_data[7:0] = 8'($urandom);
    req_data[15:8] = 8'($urandom);
    left[0] = 1; left[1] = 0;
    req_valid = 4'b0011;
    n = 0;
    while (pos_m < 3 && n < 500) begin cyc(); n++; end
    check("mid_reach", pos_m >= 3, 1);
    check("mid_first", (grants.size() > 0) ? grants[0] : -1, 0);
    do_reset();
    grants.delete();
    wait_idle("mid_done", 1000);
    check("mid_regrant", (grants.size() > 0) ? grants[0] : -1, 0);
    check("mid_count", grants.size(), 2);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Transmitter never raises busy
    baud_div = 16'd3;
    do_reset();
    tx_dead = 1'b1;
    t_start_obs = -1; t_err_obs = -1;
    req_data[7:0] = 8'($urandom);
    left[0] = 0;
    req_valid = 4'b0001;
    n = 0;
    while (t_err_obs < 0 && n < 200) begin cyc(); n++; end
    check("to_latency", t_err_obs - t_start_obs, 16);
    check("to_idle", active, 0);
    tx_dead = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
